// File: rtl/sample_packer_16_to_32.sv
// Packs pairs of 16-bit half-words into 32-bit words (first half in the upper bits)
// and queues them with a per-word burst-end flag in a small circular buffer.
module sample_packer_16_to_32 #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic        dsp_clk,
    input  logic        dsp_rst,
    input  logic [15:0] dat_i,
    input  logic        last_i,
    input  logic        enq_en_i,
    output logic        enq_rdy_o,
    output logic [31:0] dat_o,
    output logic        last_o,
    input  logic        deq_en_i,
    output logic        deq_rdy_o,
    output logic [15:0] word_cnt_o,
    output logic        err_o
);

    localparam int unsigned HALF_W  = 16;
    localparam int unsigned WORD_W  = 2 * HALF_W;
    localparam int unsigned ENTRY_W = WORD_W + 1;
    localparam int unsigned CNT_W   = PTR_WIDTH + 1;

    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [HALF_W-1:0]    HALF_ZERO  = '0;

    typedef enum logic {
        ST_HI,
        ST_LO
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [HALF_W-1:0]    hold;
    logic [HALF_W-1:0]    hold_next;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 enq_acc;
    logic                 deq_acc;
    logic                 push;
    logic [ENTRY_W-1:0]   push_entry;

    // Handshake status comes from registered occupancy only.
    assign enq_rdy_o = (count != CNT_FULL);
    assign deq_rdy_o = (count != '0);
    assign enq_acc   = enq_en_i && enq_rdy_o;
    assign deq_acc   = deq_en_i && deq_rdy_o;

    // Entry layout: {word, last}.
    assign dat_o  = mem[rd_ptr][ENTRY_W-1:1];
    assign last_o = mem[rd_ptr][0];

    // Pairing FSM: decide whether this half completes a word.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        push       = 1'b0;
        push_entry = '0;
        if (enq_acc) begin
            case (state)
                ST_HI: begin
                    if (last_i) begin
                        push       = 1'b1;
                        push_entry = {dat_i, HALF_ZERO, 1'b1};
                    end else begin
                        hold_next  = dat_i;
                        state_next = ST_LO;
                    end
                end
                ST_LO: begin
                    push       = 1'b1;
                    push_entry = {hold, dat_i, last_i};
                    state_next = ST_HI;
                end
                default: state_next = ST_HI;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        case ({push, deq_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge dsp_clk or posedge dsp_rst) begin
        if (dsp_rst) begin
            state <= ST_HI;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // Whole buffer is cleared so the head reads zero straight out of reset.
    always_ff @(posedge dsp_clk or posedge dsp_rst) begin
        if (dsp_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge dsp_clk or posedge dsp_rst) begin
        if (dsp_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // Push counter and sticky protocol-violation flag.
    always_ff @(posedge dsp_clk or posedge dsp_rst) begin
        if (dsp_rst) begin
            word_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (push) begin
                word_cnt_o <= word_cnt_o + 16'd1;
            end
            if ((enq_en_i && !enq_rdy_o) || (deq_en_i && !deq_rdy_o)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_packer_16_to_32.sv
// Directed bench for sample_packer_16_to_32: a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_sample_packer_16_to_32;

    localparam int unsigned DEPTH = 4;

    logic        dsp_clk;
    logic        dsp_rst;
    logic [15:0] dat_i;
    logic        last_i;
    logic        enq_en_i;
    logic        enq_rdy_o;
    logic [31:0] dat_o;
    logic        last_o;
    logic        deq_en_i;
    logic        deq_rdy_o;
    logic [15:0] word_cnt_o;
    logic        err_o;

    sample_packer_16_to_32 #(.DEPTH(4), .PTR_WIDTH(2)) dut (
        .dsp_clk   (dsp_clk),
        .dsp_rst   (dsp_rst),
        .dat_i     (dat_i),
        .last_i    (last_i),
        .enq_en_i  (enq_en_i),
        .enq_rdy_o (enq_rdy_o),
        .dat_o     (dat_o),
        .last_o    (last_o),
        .deq_en_i  (deq_en_i),
        .deq_rdy_o (deq_rdy_o),
        .word_cnt_o(word_cnt_o),
        .err_o     (err_o)
    );

    initial dsp_clk = 1'b0;
    always #5 dsp_clk = ~dsp_clk;

    int checks;
    int failures;

    // Reference model: words as {data, last}, pending upper half, counters.
    logic [32:0] m_q[$];
    logic        m_have;
    logic [15:0] m_half;
    logic [15:0] m_wcnt;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_have = 1'b0;
        m_half = '0;
        m_wcnt = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        logic enq_ok;
        logic deq_ok;
        enq_ok = enq_en_i && (m_q.size() != DEPTH);
        deq_ok = deq_en_i && (m_q.size() != 0);
        if ((enq_en_i && !enq_ok) || (deq_en_i && !deq_ok)) m_err = 1'b1;
        if (deq_ok) void'(m_q.pop_front());
        if (enq_ok) begin
            if (m_have) begin
                m_q.push_back({m_half, dat_i, last_i});
                m_have = 1'b0;
                m_wcnt = m_wcnt + 16'd1;
            end else if (last_i) begin
                m_q.push_back({dat_i, 16'h0000, 1'b1});
                m_wcnt = m_wcnt + 16'd1;
            end else begin
                m_have = 1'b1;
                m_half = dat_i;
            end
        end
    endtask

    task automatic compare_all();
        chk("enq_rdy", 32'(enq_rdy_o), 32'(m_q.size() != DEPTH));
        chk("deq_rdy", 32'(deq_rdy_o), 32'(m_q.size() != 0));
        chk("word_cnt", 32'(word_cnt_o), 32'(m_wcnt));
        chk("err", 32'(err_o), 32'(m_err));
        if (dsp_rst) begin
            chk("rst_dat", dat_o, 32'h0);
            chk("rst_last", 32'(last_o), 32'h0);
        end else if (m_q.size() != 0) begin
            chk("head_dat", dat_o, m_q[0][32:1]);
            chk("head_last", 32'(last_o), 32'(m_q[0][0]));
        end
    endtask

    // One clock: drive after the falling edge, model at the rising edge, compare at the next fall.
    task automatic cyc(input logic en, input logic [15:0] d, input logic l, input logic dq);
        enq_en_i = en;
        dat_i    = d;
        last_i   = l;
        deq_en_i = dq;
        @(posedge dsp_clk);
        model_step();
        @(negedge dsp_clk);
        compare_all();
    endtask

    task automatic do_reset();
        enq_en_i = 1'b0;
        deq_en_i = 1'b0;
        dsp_rst  = 1'b1;
        #1;
        model_clear();
        compare_all();
        @(posedge dsp_clk);
        @(negedge dsp_clk);
        dsp_rst = 1'b0;
        compare_all();
    endtask

    logic [31:0] exp_words [4];

    initial begin
        checks   = 0;
        failures = 0;
        dat_i    = '0;
        last_i   = 1'b0;
        enq_en_i = 1'b0;
        deq_en_i = 1'b0;
        model_clear();

        do_reset();
        chk("reset_enq_rdy", 32'(enq_rdy_o), 32'h1);
        chk("reset_deq_rdy", 32'(deq_rdy_o), 32'h0);

        // Basic pair with last on the second half.
        cyc(1'b1, 16'h1111, 1'b0, 1'b0);
        chk("pair_not_yet", 32'(deq_rdy_o), 32'h0);
        cyc(1'b1, 16'h2222, 1'b1, 1'b0);
        chk("pair_dat", dat_o, 32'h11112222);
        chk("pair_last", 32'(last_o), 32'h1);
        chk("pair_wcnt", 32'(word_cnt_o), 32'h1);

        // Lone last half zero-pads; simultaneous push/pop; FSM stays HI.
        cyc(1'b1, 16'hABCD, 1'b1, 1'b1);
        chk("pad_dat", dat_o, 32'hABCD0000);
        chk("pad_last", 32'(last_o), 32'h1);
        cyc(1'b1, 16'h1234, 1'b1, 1'b1);
        chk("still_hi_dat", dat_o, 32'h12340000);
        chk("still_hi_wcnt", 32'(word_cnt_o), 32'h3);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("drained", 32'(deq_rdy_o), 32'h0);

        // Fill to DEPTH, then an illegal enqueue.
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        chk("full_enq_rdy", 32'(enq_rdy_o), 32'h0);
        cyc(1'b1, 16'h0009, 1'b0, 1'b0);
        chk("full_err", 32'(err_o), 32'h1);
        chk("full_wcnt", 32'(word_cnt_o), 32'h4);
        chk("full_head", dat_o, 32'h00010002);
        exp_words[0] = 32'h00010002;
        exp_words[1] = 32'h00030004;
        exp_words[2] = 32'h00050006;
        exp_words[3] = 32'h00070008;
        for (int i = 0; i < 4; i++) begin
            chk("drain_word", dat_o, exp_words[i]);
            chk("drain_last", 32'(last_o), 32'h0);
            cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        end
        chk("drain_empty", 32'(deq_rdy_o), 32'h0);

        // Dequeue on empty sets the sticky error.
        do_reset();
        chk("err_cleared", 32'(err_o), 32'h0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("deq_empty_err", 32'(err_o), 32'h1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("err_sticky", 32'(err_o), 32'h1);

        // Streaming: enqueue every cycle while draining whenever non-empty.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'(16'hA000 + i), 1'(i % 3 == 2), m_q.size() != 0);
            chk("stream_enq_rdy", 32'(enq_rdy_o), 32'h1);
        end

        // Reset mid-pair drops the held half.
        do_reset();
        cyc(1'b1, 16'h5555, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0);
        chk("midpair_dat", dat_o, 32'h00010002);
        chk("midpair_wcnt", 32'(word_cnt_o), 32'h1);

        // Word counter wraps after 65537 pushes.
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            cyc(1'b1, 16'(i), 1'b1, m_q.size() != 0);
        end
        chk("wrap_wcnt", 32'(word_cnt_o), 32'h1);
        chk("wrap_err", 32'(err_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
